// File: rtl/seq_controller.sv
// ----------------------------------------------------------------------------
// seq_controller
//
// Control sequencer for a small accumulator CPU. Each instruction is fetched,
// decoded, and then executed, with memory handshakes in FETCH and EXEC. The
// sequencer produces the datapath strobes and counts retired instructions.
//
// Parameters
//   OPW    opcode width (3..5); opcodes 8 and above are illegal
//   CNT_W  width of the retired-instruction counter (wraps)
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   opcode      instruction opcode, stable from DECODE through EXEC
//   acc_zero    accumulator-equals-zero flag (SKZ condition)
//   mem_ready   memory access completes this cycle
//   resume      leave HALTED (ignored in every other state)
//   ir_load     load instruction register
//   pc_inc      increment PC
//   pc_load     load PC (jump)
//   mem_read    memory read strobe
//   mem_write   memory write strobe
//   acc_write   accumulator write enable
//   alu_to_acc  accumulator source: 1 = ALU, 0 = memory
//   alu_op      01 ADD, 10 AND, 11 XOR, 00 pass
//   halt        sequencer is halted
//   illegal     one-cycle pulse on an illegal opcode in DECODE
//   state       current FSM state (debug)
//   retired     completed-instruction count
// ----------------------------------------------------------------------------
module seq_controller #(
    parameter int OPW   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic             acc_zero,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_read,
    output logic             mem_write,
    output logic             acc_write,
    output logic             alu_to_acc,
    output logic [1:0]       alu_op,
    output logic             halt,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_HALTED = 3'd3;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Any set bit above bit 2 makes the opcode illegal; with OPW=3 the shift
    // leaves nothing, so every opcode is legal.
    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return (op >> 3) != '0;
    endfunction

    // Instructions that wait on a memory handshake in EXEC.
    function automatic logic uses_mem(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
               (op == OP_LDA) || (op == OP_STO);
    endfunction

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] retired_q;
    logic [2:0]       op3;
    logic             op_bad;
    logic             retire;

    assign op3     = opcode[2:0];
    assign op_bad  = is_illegal(opcode);
    assign state   = state_q;
    assign retired = retired_q;

    // An instruction retires when EXEC is left, or straight out of DECODE when
    // it never reaches EXEC (illegal opcode or HLT).
    assign retire = ((state_q == S_EXEC) && (state_d != S_EXEC)) ||
                    ((state_q == S_DECODE) && (op_bad || (op3 == OP_HLT)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (op_bad) begin
                    state_d = S_FETCH;
                end else if (op3 == OP_HLT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Memory instructions hold EXEC until the handshake; SKZ and
                // JMP take exactly one cycle.
                if (uses_mem(op3) && !mem_ready) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                state_d = resume ? S_FETCH : S_HALTED;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        acc_write  = 1'b0;
        alu_to_acc = 1'b0;
        alu_op     = 2'b00;
        halt       = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            S_DECODE: begin
                illegal = op_bad;
            end
            S_EXEC: begin
                case (op3)
                    OP_ADD, OP_AND, OP_XOR: begin
                        mem_read = 1'b1;
                        // The ALU select is only presented on the cycle the
                        // result is actually written.
                        if (mem_ready) begin
                            acc_write  = 1'b1;
                            alu_to_acc = 1'b1;
                            case (op3)
                                OP_ADD:  alu_op = 2'b01;
                                OP_AND:  alu_op = 2'b10;
                                default: alu_op = 2'b11;
                            endcase
                        end
                    end
                    OP_LDA: begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            acc_write = 1'b1;
                        end
                    end
                    OP_STO: begin
                        mem_write = 1'b1;
                    end
                    OP_SKZ: begin
                        pc_inc = acc_zero;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_seq_controller.sv
// ----------------------------------------------------------------------------
// tb_seq_controller
//
// Bench for seq_controller built with OPW=4 (so illegal opcodes exist) and
// CNT_W=2 (so the retired counter wraps quickly). Each instruction is described
// as a sequence of per-cycle expected output vectors derived from its phases
// (fetch waits, fetch, decode, exec waits, exec completion); a compare process
// checks every cycle on the falling edge. Literal checks pin key values.
// ----------------------------------------------------------------------------
module tb_seq_controller;

    localparam int OPW   = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [OPW-1:0]   opcode = '0;
    logic             acc_zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             resume = 1'b0;
    logic             ir_load, pc_inc, pc_load, mem_read, mem_write;
    logic             acc_write, alu_to_acc, halt, illegal;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    seq_controller #(.OPW(OPW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .acc_zero  (acc_zero),
        .mem_ready (mem_ready),
        .resume    (resume),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .acc_write (acc_write),
        .alu_to_acc(alu_to_acc),
        .alu_op    (alu_op),
        .halt      (halt),
        .illegal   (illegal),
        .state     (state),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          m_ret  = 0;
    logic        chk_en = 1'b0;
    logic [13:0] exp_vec = '0;
    logic [13:0] act_vec;

    assign act_vec = {ir_load, pc_inc, pc_load, mem_read, mem_write, acc_write,
                      alu_to_acc, alu_op, halt, illegal, state};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output vector in the same field order as act_vec.
    function automatic logic [13:0] ev(input logic ir, input logic pi, input logic pl,
                                       input logic mr, input logic mw, input logic aw,
                                       input logic ata, input logic [1:0] aop,
                                       input logic h, input logic il, input logic [2:0] st);
        return {ir, pi, pl, mr, mw, aw, ata, aop, h, il, st};
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("outputs", {18'b0, act_vec}, {18'b0, exp_vec});
            check("retired", {30'b0, retired}, {30'b0, m_ret[CNT_W-1:0]});
        end
    end

    // Apply one cycle of inputs with its expected outputs, then advance.
    task automatic step(input logic [OPW-1:0] op, input logic mr, input logic az,
                        input logic rs, input logic [13:0] e);
        opcode    = op;
        mem_ready = mr;
        acc_zero  = az;
        resume    = rs;
        exp_vec   = e;
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fw fetch wait cycles, ew exec wait cycles.
    // resume and mem_ready are deliberately driven high where they must be
    // ignored.
    task automatic run_instr(input int op, input int fw, input int ew, input logic az);
        logic [OPW-1:0] o;
        logic [1:0]     aop;
        logic           alu;
        logic           bad;
        o   = op[OPW-1:0];
        bad = (op >= 8);
        for (int i = 0; i < fw; i++)
            step(o, 1'b0, az, 1'b1, ev(0,0,0,1,0,0,0,2'b00,0,0,3'd0));
        step(o, 1'b1, az, 1'b0, ev(1,1,0,1,0,0,0,2'b00,0,0,3'd0));
        step(o, 1'b1, az, 1'b1, ev(0,0,0,0,0,0,0,2'b00,0,bad,3'd1));
        if (bad || op == 0) begin
            m_ret++;
            return;
        end
        case (op)
            2, 3, 4, 5: begin
                aop = (op == 2) ? 2'b01 : (op == 3) ? 2'b10 : (op == 4) ? 2'b11 : 2'b00;
                alu = (op != 5);
                for (int i = 0; i < ew; i++)
                    step(o, 1'b0, az, 1'b1, ev(0,0,0,1,0,0,0,2'b00,0,0,3'd2));
                step(o, 1'b1, az, 1'b0, ev(0,0,0,1,0,1,alu,aop,0,0,3'd2));
            end
            6: begin
                for (int i = 0; i < ew; i++)
                    step(o, 1'b0, az, 1'b0, ev(0,0,0,0,1,0,0,2'b00,0,0,3'd2));
                step(o, 1'b1, az, 1'b0, ev(0,0,0,0,1,0,0,2'b00,0,0,3'd2));
            end
            1: step(o, 1'b0, az, 1'b1, ev(0,az,0,0,0,0,0,2'b00,0,0,3'd2));
            default: step(o, 1'b0, az, 1'b1, ev(0,0,1,0,0,0,0,2'b00,0,0,3'd2));
        endcase
        m_ret++;
    endtask

    // n cycles halted with resume low, then a one-cycle resume pulse.
    task automatic halted(input int n);
        for (int i = 0; i < n; i++)
            step('0, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,2'b00,1,0,3'd3));
        check("halt_persist_state", {29'b0, state}, 32'd3);
        step('0, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,2'b00,1,0,3'd3));
        check("resume_to_fetch", {29'b0, state}, 32'd0);
        check("resume_halt_low", {31'b0, halt}, 32'd0);
    endtask

    initial begin
        // Reset held across edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {29'b0, state}, 32'd0);
        check("rst_retired", {30'b0, retired}, 32'd0);
        check("rst_halt", {31'b0, halt}, 32'd0);
        rst    = 1'b0;
        m_ret  = 0;
        chk_en = 1'b1;

        // LDA with memory always ready
        run_instr(5, 0, 0, 1'b0);
        check("lda_retired", {30'b0, retired}, 32'd1);

        run_instr(2, 1, 2, 1'b0);  // ADD, EXEC lasts 3 cycles
        run_instr(3, 0, 1, 1'b0);  // AND
        run_instr(4, 2, 0, 1'b1);  // XOR
        run_instr(1, 0, 0, 1'b1);  // SKZ taken
        run_instr(1, 1, 0, 1'b0);  // SKZ not taken
        run_instr(6, 0, 3, 1'b0);  // STO with waits
        run_instr(7, 0, 0, 1'b0);  // JMP
        run_instr(9, 0, 0, 1'b0);  // illegal
        check("illegal_to_fetch", {29'b0, state}, 32'd0);
        run_instr(15, 1, 0, 1'b0); // illegal, top code
        run_instr(0, 0, 0, 1'b0);  // HLT
        halted(10);
        run_instr(5, 1, 1, 1'b0);

        // Asynchronous reset between edges
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("async_rst_retired", {30'b0, retired}, 32'd0);
        check("async_rst_state", {29'b0, state}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_ret  = 0;
        chk_en = 1'b1;

        // Five JMPs wrap a 2-bit counter to 1
        for (int i = 0; i < 5; i++) run_instr(7, 0, 0, 1'b0);
        check("jmp_wrap", {30'b0, retired}, 32'd1);

        // STO interrupted by reset during its memory wait
        step(4'd6, 1'b1, 1'b0, 1'b0, ev(1,1,0,1,0,0,0,2'b00,0,0,3'd0));
        step(4'd6, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,2'b00,0,0,3'd1));
        step(4'd6, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,0,0,2'b00,0,0,3'd2));
        step(4'd6, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,0,0,2'b00,0,0,3'd2));
        chk_en = 1'b0;
        check("sto_wait_write", {31'b0, mem_write}, 32'd1);
        check("sto_wait_state", {29'b0, state}, 32'd2);
        rst = 1'b1;
        #1;
        check("sto_abort_write", {31'b0, mem_write}, 32'd0);
        check("sto_abort_state", {29'b0, state}, 32'd0);
        check("sto_abort_retired", {30'b0, retired}, 32'd0);
        check("sto_abort_accw", {31'b0, acc_write}, 32'd0);
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("sto_abort_hold_retired", {30'b0, retired}, 32'd0);
        check("sto_abort_hold_state", {29'b0, state}, 32'd0);
        rst    = 1'b0;
        m_ret  = 0;
        chk_en = 1'b1;

        // First fetch after reset waits for mem_ready
        run_instr(5, 2, 0, 1'b0);
        run_instr(2, 0, 0, 1'b0);
        check("post_rst_retired", {30'b0, retired}, 32'd2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter OPW, default 3, is the opcode width; legal values are 3..5.
REQ-002 Parameter CNT_W, default 8, is the width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  OPW  current instruction opcode; held stable by the instruction register from DECODE through EXEC.
REQ-006 acc_zero  input  1  accumulator-equals-zero flag.
REQ-007 mem_ready  input  1  memory completion handshake; when high, the current read or write completes this cycle.
REQ-008 resume  input  1  restart request while halted.
REQ-009 ir_load, pc_inc, pc_load  output  1 each  instruction-register load, PC increment, and PC load (jump).
REQ-010 mem_read, mem_write  output  1 each  memory strobes.
REQ-011 acc_write, alu_to_acc  output  1 each  accumulator write enable, and accumulator source select (1 = ALU, 0 = memory).
REQ-012 alu_op  output  2  ALU operation select: 01 ADD, 10 AND, 11 XOR, 00 pass.
REQ-013 halt, illegal  output  1 each  halted indication, and illegal-opcode pulse.
REQ-014 state  output  3  current FSM state, for debug.
REQ-015 retired  output  CNT_W  count of completed instructions.

Function
REQ-016 Opcode map: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP; any value ≥8 (when OPW>3) is illegal.
REQ-017 States and encoding: FETCH=0, DECODE=1, EXEC=2, HALTED=3; encodings 4..7 are unused and fall through to FETCH on the next edge.
REQ-018 Every output not explicitly asserted below is 0; outputs are combinational from state, opcode, acc_zero and mem_ready.
REQ-019 FETCH:
- mem_read=1.
- If mem_ready=1: ir_load=1 and pc_inc=1; next state DECODE.
- Otherwise stay in FETCH.
REQ-020 DECODE:
- All strobes are 0.
- HLT goes to HALTED.
- An illegal opcode pulses illegal=1 for this cycle, increments retired, and goes to FETCH.
- All other opcodes go to EXEC.
REQ-021 EXEC for ADD/AND/XOR:
- mem_read=1, alu_op per REQ-012.
- When mem_ready=1: acc_write=1 and alu_to_acc=1, then go to FETCH.
- Otherwise stay in EXEC.
REQ-022 EXEC for LDA: mem_read=1; when mem_ready=1, acc_write=1 with alu_to_acc=0, then go to FETCH.
REQ-023 EXEC for STO: mem_write=1 held until mem_ready=1, then go to FETCH; acc_write=0 throughout.
REQ-024 EXEC for SKZ: one cycle; pc_inc=acc_zero; then go to FETCH.
REQ-025 EXEC for JMP: one cycle; pc_load=1; then go to FETCH.
REQ-026 HALTED:
- halt=1 and all strobes are 0.
- resume=1 goes to FETCH on the next edge; otherwise stay in HALTED.
- resume has no effect in any other state.
REQ-027 retired increments by 1 on the edge leaving EXEC and on the edge leaving DECODE for illegal or HLT; it wraps from 2^CNT_W-1 to 0.
REQ-028 Latency: a memory-free instruction (SKZ, JMP) takes 3 cycles including FETCH; a memory instruction takes 3 + wait cycles per access.
REQ-029 mem_read and mem_write are never asserted in the same cycle.
REQ-030 pc_inc and pc_load are never asserted in the same cycle.

Reset
REQ-031 While rst=1, state=FETCH, retired=0 and halt=0, independent of clk.
REQ-032 Reset asserted mid-EXEC or mid-wait aborts the instruction; no acc_write or retired increment is produced.
REQ-033 First fetch: after rst deasserts, the first rising edge with mem_ready=1 completes the first fetch.

Verification
REQ-034 LDA, mem_ready=1 on all cycles:
- FETCH: ir_load=1 and pc_inc=1.
- DECODE: all strobes 0.
- EXEC: mem_read=1 and acc_write=1 with alu_to_acc=0.
- Then retired=1.
REQ-035 ADD with mem_ready low for 2 EXEC cycles: EXEC lasts 3 cycles; acc_write=1 and alu_op=01 only in the third cycle.
REQ-036 SKZ:
- acc_zero=1 gives pc_inc=1 in EXEC.
- acc_zero=0 gives pc_inc=0 in EXEC.
- pc_load=0 in both cases.
REQ-037 HLT:
- After DECODE, halt=1 and it persists 10 cycles with resume=0.
- A 1-cycle resume pulse returns state to FETCH.
REQ-038 OPW=4, opcode=9: illegal=1 for exactly the DECODE cycle; next state FETCH; no memory strobe.
REQ-039 CNT_W=2: after 5 JMPs retired=1 (wrapped). Then rst asserted mid-STO wait: mem_write drops at once, state=0 and retired=0.
